// File: rtl/window_analysis_pkg.sv
// ---------------------------------------------------------------------------
// window_analysis_pkg
// Shared definitions for the window_analysis result path:
//   - analyser geometry and the derived READ_DATA_SIZE of one FIFO record
//   - record field widths/offsets {cycle_number, zero_offset, max_amp, max_time}
//   - FIFO state bit indices, frame header byte, packer state encoding
//   - helpers to slice a padded record into bytes and to fold its checksum
// Optional feature macro: WINDOW_PACKER_CHECKSUM_EN (adds the CSUM state).
// ---------------------------------------------------------------------------
package window_analysis_pkg;

    localparam int SAMPLE_DATA_SIZE  = 4;
    localparam int WINDOW_POW_SIZE   = 5;
    localparam int CYCLE_NUMBER_SIZE = 5;
    localparam int READ_DATA_SIZE    = WINDOW_POW_SIZE + 2*SAMPLE_DATA_SIZE
                                     + $clog2(WINDOW_POW_SIZE) - 1 + CYCLE_NUMBER_SIZE;

    // Record field widths, LSB field first
    localparam int MAX_TIME_W    = SAMPLE_DATA_SIZE;
    localparam int MAX_AMP_W     = SAMPLE_DATA_SIZE;
    localparam int ZERO_OFFSET_W = WINDOW_POW_SIZE + $clog2(WINDOW_POW_SIZE) - 1;
    localparam int CYCLE_W       = CYCLE_NUMBER_SIZE;

    localparam int MAX_TIME_OFS    = 0;
    localparam int MAX_AMP_OFS     = MAX_TIME_OFS + MAX_TIME_W;
    localparam int ZERO_OFFSET_OFS = MAX_AMP_OFS + MAX_AMP_W;
    localparam int CYCLE_OFS       = ZERO_OFFSET_OFS + ZERO_OFFSET_W;

    // fifo_state_in bit positions
    localparam int FIFO_FULL   = 3;
    localparam int FIFO_EMPTY  = 2;
    localparam int FIFO_AFULL  = 1;
    localparam int FIFO_AEMPTY = 0;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    // Record is zero-padded in its MSBs up to a whole number of bytes
    localparam int NBYTES = (READ_DATA_SIZE + 7) / 8;
    localparam int PAD_W  = 8 * NBYTES;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam int LAT_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HDR  = 3'd3,
        ST_DATA = 3'd4
`ifdef WINDOW_PACKER_CHECKSUM_EN
        ,
        ST_CSUM = 3'd5
`endif
    } packer_state_e;

    // Byte idx of the padded record (idx 0 = least significant byte)
    function automatic logic [7:0] record_byte(input logic [PAD_W-1:0] rec, input int idx);
        return rec[idx*8 +: 8];
    endfunction

    // XOR of all record bytes; header is not part of the checksum
    function automatic logic [7:0] record_xor(input logic [PAD_W-1:0] rec);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            acc = acc ^ rec[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/window_byte_tx.sv
// ---------------------------------------------------------------------------
// window_byte_tx
// Single-entry output byte register for a valid/ready stream. A load places a
// byte (and its last flag) in the register and raises valid; the byte is held
// unchanged until the sink accepts it. The controller only loads when the slot
// is free or being accepted in the same clock, so no skid buffer is needed.
// Ports:
//   clk        in   clock
//   i_nrst     in   synchronous active-low reset
//   i_load     in   write i_data/i_last into the slot, valid=1
//   i_data     in   byte to send
//   i_last     in   last-byte-of-frame flag for i_data
//   i_ready    in   sink ready
//   o_data     out  registered stream byte
//   o_valid    out  registered valid
//   o_last     out  registered last flag
//   o_accept   out  o_valid && i_ready (handshake completes this clock)
// ---------------------------------------------------------------------------
module window_byte_tx (
    input  logic       clk,
    input  logic       i_nrst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_last,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_last,
    output logic       o_accept
);

    logic [7:0] r_data;
    logic       r_valid;
    logic       r_last;

    // Byte slot: load has priority over the accept that frees the slot
    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_data  <= r_data;
            r_valid <= r_valid;
            r_last  <= r_last;
        end
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_last   = r_last;
    assign o_accept = r_valid && i_ready;

endmodule

// File: rtl/window_result_packer.sv
// ---------------------------------------------------------------------------
// window_result_packer
// Drains the window_analysis result FIFO one record at a time and sends each
// record as a byte frame: HEADER_BYTE, record bytes MSB first, and (with
// WINDOW_PACKER_CHECKSUM_EN defined) an XOR checksum of the record bytes.
// Ports:
//   clk              in   system clock
//   nrst_in          in   synchronous active-low reset
//   fifo_state_in    in   [3] full [2] empty [1] almost full [0] almost empty
//   read_data_in     in   record {cycle_number, zero_offset, max_amp, max_time}
//   read_enable_out  out  one-clock FIFO pop strobe
//   tx_data_out      out  stream byte
//   tx_valid_out     out  stream valid
//   tx_ready_in      in   stream ready
//   tx_last_out      out  last byte of frame
//   busy_out         out  FSM not idle
//   overflow_out     out  sticky FIFO-full flag
//   clear_in         in   clears overflow_out (a full in the same clock wins)
//   frame_count_out  out  completed frames, wraps
// Macro: WINDOW_PACKER_CHECKSUM_EN enables the trailing checksum byte.
// ---------------------------------------------------------------------------
module window_result_packer
    import window_analysis_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      nrst_in,
    input  logic [3:0]                fifo_state_in,
    input  logic [READ_DATA_SIZE-1:0] read_data_in,
    output logic                      read_enable_out,
    output logic [7:0]                tx_data_out,
    output logic                      tx_valid_out,
    input  logic                      tx_ready_in,
    output logic                      tx_last_out,
    output logic                      busy_out,
    output logic                      overflow_out,
    input  logic                      clear_in,
    output logic [15:0]               frame_count_out
);

`ifdef WINDOW_PACKER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    packer_state_e             r_state;
    logic [READ_DATA_SIZE-1:0] r_record;
    logic [LAT_W-1:0]          r_lat_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_read_enable;
    logic                      r_busy;
    logic                      r_overflow;
    logic [15:0]               r_frame_count;

    logic [PAD_W-1:0] w_rec_pad;
    logic             w_load;
    logic [7:0]       w_load_data;
    logic             w_load_last;
    logic             w_accept;
    logic             w_unused;

    assign w_rec_pad = PAD_W'(r_record);
    // Almost-full/almost-empty are informational only for this drain
    assign w_unused  = &{1'b0, fifo_state_in[FIFO_AFULL], fifo_state_in[FIFO_AEMPTY]};

    // Byte to load into the output slot: header as the record is captured,
    // then the next data (or checksum) byte on each accept
    always_comb begin
        w_load      = 1'b0;
        w_load_data = 8'h00;
        w_load_last = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (r_lat_cnt == LAT_W'(0)) begin
                    w_load      = 1'b1;
                    w_load_data = HEADER_BYTE;
                end else begin
                    w_load = 1'b0;
                end
            end
            ST_HDR: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_load_data = record_byte(w_rec_pad, NBYTES - 1);
                    w_load_last = (NBYTES == 1) && !CSUM_EN;
                end else begin
                    w_load = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_accept && (r_idx != IDX_W'(0))) begin
                    w_load      = 1'b1;
                    w_load_data = record_byte(w_rec_pad, int'(r_idx) - 1);
                    w_load_last = (r_idx == IDX_W'(1)) && !CSUM_EN;
                end else if (w_accept && CSUM_EN) begin
                    w_load      = 1'b1;
                    w_load_data = record_xor(w_rec_pad);
                    w_load_last = 1'b1;
                end else begin
                    w_load = 1'b0;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    window_byte_tx u_byte_tx (
        .clk      (clk),
        .i_nrst   (nrst_in),
        .i_load   (w_load),
        .i_data   (w_load_data),
        .i_last   (w_load_last),
        .i_ready  (tx_ready_in),
        .o_data   (tx_data_out),
        .o_valid  (tx_valid_out),
        .o_last   (tx_last_out),
        .o_accept (w_accept)
    );

    // Frame sequencer: one pop, latency wait, header, data bytes, optional checksum
    always_ff @(posedge clk) begin
        if (!nrst_in) begin
            r_state       <= ST_IDLE;
            r_record      <= '0;
            r_lat_cnt     <= '0;
            r_idx         <= '0;
            r_read_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_state_in[FIFO_EMPTY]) begin
                        r_state       <= ST_POP;
                        r_read_enable <= 1'b1;
                        r_busy        <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_POP: begin
                    r_read_enable <= 1'b0;
                    r_lat_cnt     <= LAT_W'(READ_LATENCY - 1);
                    r_state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat_cnt == LAT_W'(0)) begin
                        r_record <= read_data_in;
                        r_state  <= ST_HDR;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                ST_HDR: begin
                    if (w_accept) begin
                        r_idx   <= IDX_W'(NBYTES - 1);
                        r_state <= ST_DATA;
                    end else begin
                        r_state <= ST_HDR;
                    end
                end
                ST_DATA: begin
                    if (w_accept && (r_idx != IDX_W'(0))) begin
                        r_idx <= r_idx - IDX_W'(1);
                    end else if (w_accept) begin
`ifdef WINDOW_PACKER_CHECKSUM_EN
                        r_state <= ST_CSUM;
`else
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_frame_count <= r_frame_count + 16'd1;
`endif
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
`ifdef WINDOW_PACKER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_frame_count <= r_frame_count + 16'd1;
                    end else begin
                        r_state <= ST_CSUM;
                    end
                end
`endif
                default: begin
                    r_state       <= ST_IDLE;
                    r_read_enable <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a full indication beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!nrst_in) begin
            r_overflow <= 1'b0;
        end else if (fifo_state_in[FIFO_FULL]) begin
            r_overflow <= 1'b1;
        end else if (clear_in) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign read_enable_out = r_read_enable;
    assign busy_out        = r_busy;
    assign overflow_out    = r_overflow;
    assign frame_count_out = r_frame_count;

endmodule
